// File: rtl/reg_bypass_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_bypass_ctrl: ID-stage operand bypass, busy scoreboard and stall gen.  |
// | Optional stats counters enabled by defining BYPASS_STATS_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module reg_bypass_ctrl #(
  parameter int NUM_READ      = 2,
  parameter int NUM_SRC       = 3,
  parameter int DATA_W        = 32,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*5-1:0]      rd_addr,
  input  logic [NUM_READ*DATA_W-1:0] rd_val_regs,
  input  logic [NUM_SRC*5-1:0]       src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]  src_val,
  input  logic [NUM_SRC-1:0]         src_wen,
  input  logic [NUM_SRC-1:0]         src_rdy,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_addr,
  input  logic                       retire_valid,
  input  logic [4:0]                 retire_addr,
  input  logic [DATA_W-1:0]          retire_val,
  output logic [NUM_READ*DATA_W-1:0] rd_val_out,
  output logic                       stall,
  output logic                       stall_timeout,
  output logic                       sb_err,
  output logic [31:0]                stat_stall_cnt,
  output logic [31:0]                stat_fwd_cnt
);

  localparam logic [15:0] C_TIMEOUT = 16'(STALL_TIMEOUT);

  logic [31:1]         r_busy;
  logic [15:0]         r_stall_cnt;
  logic                r_sb_err;
  logic [31:0]         w_busy;
  logic [31:0]         w_busy_nxt;
  logic [NUM_READ-1:0] w_hazard;
  logic [NUM_READ-1:0] w_fwd;
  logic                w_stall;

  assign w_busy = {r_busy, 1'b0};

  always_comb begin
    logic [4:0] addr;
    logic       found;
    w_hazard   = '0;
    w_fwd      = '0;
    rd_val_out = rd_val_regs;
    addr       = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      addr  = rd_addr[5*i +: 5];
      found = 1'b0;
      if (addr == 5'd0) begin
        rd_val_out[DATA_W*i +: DATA_W] = '0;
      end else begin
        // Youngest matching writer wins outright; a not-ready one blocks older ones.
        for (int j = 0; j < NUM_SRC; j++) begin
          if (!found && src_wen[j] && (src_addr[5*j +: 5] == addr)) begin
            found = 1'b1;
            if (src_rdy[j]) begin
              rd_val_out[DATA_W*i +: DATA_W] = src_val[DATA_W*j +: DATA_W];
              w_fwd[i] = 1'b1;
            end else begin
              w_hazard[i] = 1'b1;
            end
          end
        end
        if (!found) begin
          if (retire_valid && (retire_addr == addr)) begin
            rd_val_out[DATA_W*i +: DATA_W] = retire_val;
            w_fwd[i] = 1'b1;
          end else if (w_busy[addr]) begin
            w_hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  assign w_stall = |w_hazard;
  assign stall   = w_stall;

  // Retire clears before issue sets so a same-cycle reissue stays busy.
  always_comb begin
    w_busy_nxt = w_busy;
    if (retire_valid) w_busy_nxt[retire_addr] = 1'b0;
    if (issue_valid)  w_busy_nxt[issue_addr]  = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt[31:1];
      if (retire_valid && (retire_addr != 5'd0) && !w_busy[retire_addr])
        r_sb_err <= 1'b1;
      if (w_stall) begin
        if (r_stall_cnt != C_TIMEOUT) r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign stall_timeout = (r_stall_cnt == C_TIMEOUT);
  assign sb_err        = r_sb_err;

`ifdef BYPASS_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stall <= '0;
      r_stat_fwd   <= '0;
    end else begin
      if (w_stall)             r_stat_stall <= r_stat_stall + 32'd1;
      if (!w_stall && |w_fwd)  r_stat_fwd   <= r_stat_fwd + 32'd1;
    end
  end

  assign stat_stall_cnt = r_stat_stall;
  assign stat_fwd_cnt   = r_stat_fwd;
`else
  logic w_unused_fwd;
  assign w_unused_fwd   = |w_fwd;
  assign stat_stall_cnt = '0;
  assign stat_fwd_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bypass_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_bypass_ctrl: scoreboard bench for reg_bypass_ctrl (TIMEOUT = 4).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_reg_bypass_ctrl;

  localparam logic [31:0] C_REG0 = 32'hAAAA_0000;
  localparam logic [31:0] C_REG1 = 32'hBBBB_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_val_regs;
  logic [14:0] src_addr;
  logic [95:0] src_val;
  logic [2:0]  src_wen, src_rdy;
  logic        issue_valid, retire_valid;
  logic [4:0]  issue_addr, retire_addr;
  logic [31:0] retire_val;
  logic [63:0] rd_val_out;
  logic        stall, stall_timeout, sb_err;
  logic [31:0] stat_stall_cnt, stat_fwd_cnt;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] val;
    bit          chk_val;
    logic        stl;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  logic [31:0] m_got;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_stat;

  reg_bypass_ctrl #(
    .NUM_READ(2), .NUM_SRC(3), .DATA_W(32), .STALL_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_val_regs(rd_val_regs),
    .src_addr(src_addr), .src_val(src_val), .src_wen(src_wen), .src_rdy(src_rdy),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .retire_valid(retire_valid), .retire_addr(retire_addr), .retire_val(retire_val),
    .rd_val_out(rd_val_out), .stall(stall), .stall_timeout(stall_timeout),
    .sb_err(sb_err), .stat_stall_cnt(stat_stall_cnt), .stat_fwd_cnt(stat_fwd_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_got = rd_val_out[32*m_e.port +: 32];
      if (m_e.chk_val) begin
        total++;
        if (m_got !== m_e.val) begin
          bad++;
          $display("FAIL %s val port%0d got=%h exp=%h", m_e.name, m_e.port, m_got, m_e.val);
        end
      end
      total++;
      if (stall !== m_e.stl) begin
        bad++;
        $display("FAIL %s stall got=%b exp=%b", m_e.name, stall, m_e.stl);
      end
      total++;
      if (stall_timeout !== m_e.tmo) begin
        bad++;
        $display("FAIL %s stall_timeout got=%b exp=%b", m_e.name, stall_timeout, m_e.tmo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push(input string n, input int p, input logic [31:0] v,
                      input bit cv, input logic s, input logic t);
    exp_t e;
    e = '{n, p, v, cv, s, t};
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_addr      = '0;
    rd_val_regs  = {C_REG1, C_REG0};
    src_addr     = '0;
    src_val      = '0;
    src_wen      = '0;
    src_rdy      = '0;
    issue_valid  = 1'b0;
    issue_addr   = '0;
    retire_valid = 1'b0;
    retire_addr  = '0;
    retire_val   = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
    total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL reset_tmo got=%b exp=0", stall_timeout); end
    total++; if (stat_stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stat_stall got=%0d exp=0", stat_stall_cnt); end
    total++; if (stat_fwd_cnt !== 32'd0) begin bad++; $display("FAIL reset_stat_fwd got=%0d exp=0", stat_fwd_cnt); end
    cyc();
    rst = 1'b0;
    rd_addr = {5'd1, 5'd0};
    push("reset_port1_regs", 1, C_REG1, 1, 0, 0);
    cyc();
    push("reset_port0_r0", 0, 32'd0, 1, 0, 0);
    cyc();
  endtask

  task automatic test_priority();
    clear_inputs();
    src_addr = {5'd5, 5'd5, 5'd5};
    src_val  = {32'h33, 32'h22, 32'h11};
    src_wen  = 3'b011;
    src_rdy  = 3'b111;
    rd_addr  = {5'd0, 5'd5};
    push("prio_ex_over_mm", 0, 32'h11, 1, 0, 0);
    cyc();
    rd_addr = {5'd5, 5'd0};
    push("prio_r0_zero", 0, 32'd0, 1, 0, 0);
    cyc();
    src_wen = 3'b010;
    rd_addr = {5'd0, 5'd5};
    push("prio_mm_only", 0, 32'h22, 1, 0, 0);
    cyc();
    src_wen = 3'b100;
    push("prio_wb_only", 0, 32'h33, 1, 0, 0);
    cyc();
    rd_addr = {5'd6, 5'd6};
    push("prio_no_match", 1, C_REG1, 1, 0, 0);
    cyc();
  endtask

  task automatic test_load_use();
    clear_inputs();
    src_addr = {5'd0, 5'd7, 5'd7};
    src_val  = {32'h0, 32'h77, 32'h0};
    src_wen  = 3'b011;
    src_rdy  = 3'b010;
    rd_addr  = {5'd7, 5'd0};
    push("loaduse_stall", 1, 32'd0, 0, 1, 0);
    cyc();
    src_rdy = 3'b011;
    src_val[31:0] = 32'hABCD;
    push("loaduse_fwd", 1, 32'hABCD, 1, 0, 0);
    cyc();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    rd_addr     = {5'd0, 5'd9};
    push("sb_issue_cycle", 0, C_REG0, 1, 0, 0);
    cyc();
    issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push("sb_busy_stall", 0, 32'd0, 0, 1, 0);
      cyc();
    end
    retire_valid = 1'b1;
    retire_addr  = 5'd9;
    retire_val   = 32'h1234;
    push("sb_retire_fwd", 0, 32'h1234, 1, 0, 0);
    cyc();
    retire_valid = 1'b0;
    push("sb_after_retire", 0, C_REG0, 1, 0, 0);
    cyc();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL sb_no_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_issue_retire_same();
    clear_inputs();
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    push("same_issue", 0, 32'd0, 1, 0, 0);
    cyc();
    retire_valid = 1'b1;
    retire_addr  = 5'd3;
    retire_val   = 32'h333;
    rd_addr      = {5'd0, 5'd3};
    push("same_both_fwd", 0, 32'h333, 1, 0, 0);
    cyc();
    issue_valid  = 1'b0;
    retire_valid = 1'b0;
    push("same_still_busy", 0, 32'd0, 0, 1, 0);
    cyc();
    retire_valid = 1'b1;
    retire_val   = 32'h3;
    push("same_final_retire", 0, 32'h3, 1, 0, 0);
    cyc();
    retire_valid = 1'b0;
    push("same_free", 0, C_REG0, 1, 0, 0);
    cyc();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL same_no_err got=%b exp=0", sb_err); end
  endtask

  task automatic test_sb_err();
    clear_inputs();
    retire_valid = 1'b1;
    retire_addr  = 5'd0;
    cyc();
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL err_r0_excluded got=%b exp=0", sb_err); end
    retire_addr = 5'd4;
    retire_val  = 32'h44;
    rd_addr     = {5'd0, 5'd4};
    push("err_retire_fwd", 0, 32'h44, 1, 0, 0);
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL err_not_yet got=%b exp=0", sb_err); end
    cyc();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", sb_err); end
    clear_inputs();
    cyc();
    cyc();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", sb_err); end
  endtask

  task automatic test_timeout();
    clear_inputs();
    issue_valid = 1'b1;
    issue_addr  = 5'd12;
    cyc();
    issue_valid = 1'b0;
    rd_addr     = {5'd0, 5'd12};
    for (int k = 0; k < 6; k++) begin
      push("tmo_hold", 0, 32'd0, 0, 1, (k >= 4));
      cyc();
    end
    retire_valid = 1'b1;
    retire_addr  = 5'd12;
    retire_val   = 32'hC0DE;
    push("tmo_release", 0, 32'hC0DE, 1, 0, 1);
    cyc();
    clear_inputs();
    push("tmo_cleared", 0, 32'd0, 1, 0, 0);
    cyc();
  endtask

  task automatic test_async_reset_stats();
    clear_inputs();
    issue_valid = 1'b1;
    issue_addr  = 5'd2;
    cyc();
    issue_valid = 1'b0;
    rd_addr     = {5'd0, 5'd2};
    for (int k = 0; k < 4; k++) begin
      push("ar_hold", 0, 32'd0, 0, 1, 0);
      cyc();
    end
    total++; if (stall_timeout !== 1'b1) begin bad++; $display("FAIL ar_pre_tmo got=%b exp=1", stall_timeout); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ar_busy_cleared stall got=%b exp=0", stall); end
    total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL ar_tmo_cleared got=%b exp=0", stall_timeout); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL ar_err_cleared got=%b exp=0", sb_err); end
    cyc();
    rst = 1'b0;
    total++; if (stat_stall_cnt !== 32'd0) begin bad++; $display("FAIL ar_stat_stall got=%0d exp=0", stat_stall_cnt); end
    total++; if (stat_fwd_cnt !== 32'd0) begin bad++; $display("FAIL ar_stat_fwd got=%0d exp=0", stat_fwd_cnt); end
    clear_inputs();
    issue_valid = 1'b1;
    issue_addr  = 5'd8;
    push("st_issue", 0, 32'd0, 1, 0, 0);
    cyc();
    issue_valid = 1'b0;
    rd_addr     = {5'd0, 5'd8};
    push("st_stall", 0, 32'd0, 0, 1, 0);
    cyc();
    rd_addr       = {5'd6, 5'd0};
    src_addr[4:0] = 5'd6;
    src_val[31:0] = 32'h66;
    src_wen       = 3'b001;
    src_rdy       = 3'b001;
    push("st_fwd", 1, 32'h66, 1, 0, 0);
    cyc();
    clear_inputs();
`ifdef BYPASS_STATS_EN
    exp_stat = 32'd1;
`else
    exp_stat = 32'd0;
`endif
    total++; if (stat_stall_cnt !== exp_stat) begin bad++; $display("FAIL st_stall_cnt got=%0d exp=%0d", stat_stall_cnt, exp_stat); end
    total++; if (stat_fwd_cnt !== exp_stat) begin bad++; $display("FAIL st_fwd_cnt got=%0d exp=%0d", stat_fwd_cnt, exp_stat); end
    retire_valid = 1'b1;
    retire_addr  = 5'd2;
    retire_val   = 32'h22;
    cyc();
    clear_inputs();
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL ar_stale_retire_err got=%b exp=1", sb_err); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_scoreboard();
    test_issue_retire_same();
    test_sb_err();
    test_timeout();
    test_async_reset_stats();
    cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
